data_bus_responder: RTL
=======================

# data_bus_responder

Slave end of the CPU data-memory bus: answers the core's `mem_cs`/`mem_we`/`mem_oe`/`mem_addr`/`mem_data` accesses with a 120-byte SRAM plus a memory-mapped 8-bit timer and GPIO port in the top 8 addresses. It sits beside `cpu` in the top level, sharing its clock. It raises a level interrupt request from timer events.

## Interface
- `DATA_WIDTH`, 8: data/register width; timer and GPIO are this width; only 8 is supported.
- `D_ADDR_WIDTH`, 7: byte address width; 128-byte space.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `mem_cs` in 1: access select.
- `mem_we` in 1: write strobe.
- `mem_oe` in 1: read/output enable.
- `mem_addr` in `D_ADDR_WIDTH`: byte address.
- `mem_data` inout `DATA_WIDTH`: write data in; read data out.
- `gpio_in` in 8: asynchronous external inputs.
- `gpio_out` out 8: GPIO output register.
- `irq` out 1: level interrupt, `|(TIFR[1:0] & TIMSK[1:0])`.

## Operation
- Address map:
  - 0x00–0x77: RAM.
  - 0x78 TCNT: R/W.
  - 0x79 TCCR: bit0 EN; bits2:1 PS (00 /1, 01 /8, 10 /64, 11 /256); bit3 CTC.
  - 0x7A OCR: R/W.
  - 0x7B TIFR: bit0 OVF, bit1 CMP; write-1-to-clear.
  - 0x7C GPIO_OUT: R/W.
  - 0x7D GPIO_IN: read-only; writes ignored.
  - 0x7E TIMSK: bits1:0.
  - 0x7F: reserved; reads 0, writes ignored.
- Unused register bits read 0.
- Write: at a rising edge with `mem_cs & mem_we`, store `mem_data` to the addressed location. `mem_oe` is ignored while `mem_we`=1.
- Read: drive `mem_data` only when `mem_cs & mem_oe & ~mem_we`; high-Z otherwise.
- Prescaler: 8-bit counter, runs only while EN=1 and is held at 0 while EN=0. A tick is generated when it reaches divisor−1; it then wraps to 0. With PS=00, every enabled cycle is a tick.
- On a tick:
  - If CTC=1 and TCNT==OCR: TCNT←0 and CMP←1.
  - Else if TCNT==OCR: CMP←1 and TCNT←TCNT+1.
  - TCNT==0xFF with no CTC match: TCNT wraps to 0 and OVF←1.
  - CTC=1 with OCR=0xFF: CMP and OVF both set; TCNT←0.
- Simultaneous events:
  - CPU write to TCNT in a tick cycle: the write wins; no increment and no flags from that tick.
  - Write-1-clear of a TIFR bit in the same cycle as a hardware set of that bit: the set wins.
  - Write to TCCR changing PS: the prescaler clears to 0.
- `gpio_in` passes through a two-flop synchronizer; GPIO_IN returns the second flop.

## Timing
- Reset (asynchronous, `reset`=0):
  - Cleared to 0: TCNT, TCCR, OCR, TIFR, TIMSK, GPIO_OUT, prescaler, synchronizer flops.
  - Outputs: `gpio_out`=0, `irq`=0, `mem_data` high-Z.
  - RAM contents are not reset and are undefined until written.
  - Reset mid-access aborts the access: no write occurs.
- Read latency is 0 cycles: combinational from RAM or registers within the same cycle. Read values are the pre-edge state.
- A write is visible to a read in the cycle after the write edge.
- `gpio_out` and `irq` are registered/derived from registers and update one edge after the causing write or tick.
- A `gpio_in` change is readable after 2 rising edges.
- Timer period: (divisor) × (OCR+1) cycles in CTC mode; divisor × 256 cycles for overflow in normal mode.

## Structure
- `defines.vh` holds:
  - address constants `ADDR_TCNT`…`ADDR_TIMSK` and `RAM_TOP` (0x77);
  - TCCR bit indices;
  - prescaler encodings and divisor constants;
  - TIFR bit indices.
- One sub-module, `data_timer8`, containing:
  - prescaler, TCNT, OCR, TCCR, TIFR;
  - write ports for those registers and a tick/flag-set output.
- The top level holds RAM, address decode, the tristate driver, GPIO and TIMSK/`irq`.

## Test plan
- RAM:
  - Write 0xA5 to 0x00, 0x3C to 0x77.
  - Read both back → 0xA5 and 0x3C.
  - `mem_data` is Z when `mem_oe`=0.
- Timer overflow:
  - Setup: TCCR=0x01, TCNT=0xFE, TIMSK=0x01.
  - After 2 cycles: TCNT=0x00, TIFR=0x01, `irq`=1.
  - Write TIFR=0x01 → `irq`=0 next cycle.
- CTC:
  - Setup: TCCR=0x0B (EN, /8, CTC), OCR=0x03.
  - Expect CMP set after 32 cycles; TCNT returns to 0.
  - Clear-vs-set collision on the tick edge → CMP stays 1.
- TCNT write in a tick cycle:
  - Write TCNT=0x10 in a tick cycle.
  - Read → 0x10, no flag change.
- GPIO:
  - Write 0x5A to 0x7C → `gpio_out`=0x5A next edge.
  - Drive `gpio_in`=0xC3; read 0x7D after 2 edges → 0xC3.
  - Read 0x7F → 0x00.
- Reset mid-operation:
  - Assert `reset`=0 while timer runs and `gpio_out`=0xFF.
  - All outputs immediately 0/Z.
  - After release, timer stays stopped.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data-bus responder: address map, timer
// register bit positions, prescaler encodings and write-strobe bundle.
package data_bus_responder_pkg;

    localparam logic [6:0] RAM_TOP    = 7'h77;
    localparam logic [6:0] ADDR_TCNT  = 7'h78;
    localparam logic [6:0] ADDR_TCCR  = 7'h79;
    localparam logic [6:0] ADDR_OCR   = 7'h7A;
    localparam logic [6:0] ADDR_TIFR  = 7'h7B;
    localparam logic [6:0] ADDR_GPO   = 7'h7C;
    localparam logic [6:0] ADDR_GPI   = 7'h7D;
    localparam logic [6:0] ADDR_TIMSK = 7'h7E;

    localparam int TCCR_EN    = 0;
    localparam int TCCR_PS_LO = 1;
    localparam int TCCR_PS_HI = 2;
    localparam int TCCR_CTC   = 3;

    localparam int TIFR_OVF = 0;
    localparam int TIFR_CMP = 1;

    localparam logic [1:0] PS_DIV1   = 2'b00;
    localparam logic [1:0] PS_DIV8   = 2'b01;
    localparam logic [1:0] PS_DIV64  = 2'b10;
    localparam logic [1:0] PS_DIV256 = 2'b11;

    localparam int DIV1   = 1;
    localparam int DIV8   = 8;
    localparam int DIV64  = 64;
    localparam int DIV256 = 256;

    typedef struct packed {
        logic tcnt;
        logic tccr;
        logic ocr;
        logic tifr;
    } tmr_wr_t;

    // Terminal prescaler count for a PS encoding (divisor - 1)
    function automatic logic [7:0] ps_last(input logic [1:0] ps);
        logic [7:0] r;
        unique case (ps)
            PS_DIV1:   r = 8'(DIV1 - 1);
            PS_DIV8:   r = 8'(DIV8 - 1);
            PS_DIV64:  r = 8'(DIV64 - 1);
            PS_DIV256: r = 8'(DIV256 - 1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_timer8.sv
// 8-bit timer: prescaler, TCNT, OCR, TCCR and TIFR with CTC and
// overflow events; CPU writes arrive as decoded strobes.
module data_timer8
    import data_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  tmr_wr_t    wr,
    input  logic [7:0] wdata,
    output logic [7:0] tcnt,
    output logic [3:0] tccr,
    output logic [7:0] ocr,
    output logic [1:0] tifr,
    output logic       tick,
    output logic [1:0] flag_set
);

    logic [7:0] psc_q, psc_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] ocr_q, ocr_d;
    logic [3:0] tccr_q, tccr_d;
    logic [1:0] tifr_q, tifr_d;
    logic       en, ctc, match, ps_chg;

    assign en     = tccr_q[TCCR_EN];
    assign ctc    = tccr_q[TCCR_CTC];
    assign match  = (tcnt_q == ocr_q);
    assign tick   = en && (psc_q == ps_last(tccr_q[TCCR_PS_HI:TCCR_PS_LO]));
    assign ps_chg = wr.tccr &&
                    (wdata[TCCR_PS_HI:TCCR_PS_LO] != tccr_q[TCCR_PS_HI:TCCR_PS_LO]);

    // Prescaler runs while enabled; restarts on wrap, disable or divisor change
    always_comb begin
        psc_d = psc_q + 8'd1;
        if (!en || tick || ps_chg) begin
            psc_d = '0;
        end
    end

    // Counter advance and event flags per tick; a CPU write to TCNT wins
    always_comb begin
        tcnt_d   = tcnt_q;
        flag_set = '0;
        if (tick) begin
            if (match) begin
                flag_set[TIFR_CMP] = 1'b1;
            end
            if (ctc && match) begin
                tcnt_d = '0;
                if (ocr_q == 8'hFF) begin
                    flag_set[TIFR_OVF] = 1'b1;
                end
            end else begin
                tcnt_d = tcnt_q + 8'd1;
                if (tcnt_q == 8'hFF) begin
                    flag_set[TIFR_OVF] = 1'b1;
                end
            end
        end
        if (wr.tcnt) begin
            tcnt_d   = wdata;
            flag_set = '0;
        end
    end

    // Control registers; hardware flag sets override write-1-to-clear
    always_comb begin
        ocr_d  = wr.ocr ? wdata : ocr_q;
        tccr_d = wr.tccr ? wdata[3:0] : tccr_q;
        tifr_d = tifr_q;
        if (wr.tifr) begin
            tifr_d = tifr_q & ~wdata[1:0];
        end
        tifr_d = tifr_d | flag_set;
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q  <= '0;
            tcnt_q <= '0;
            ocr_q  <= '0;
            tccr_q <= '0;
            tifr_q <= '0;
        end else begin
            psc_q  <= psc_d;
            tcnt_q <= tcnt_d;
            ocr_q  <= ocr_d;
            tccr_q <= tccr_d;
            tifr_q <= tifr_d;
        end
    end

    assign tcnt = tcnt_q;
    assign tccr = tccr_q;
    assign ocr  = ocr_q;
    assign tifr = tifr_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory bus slave: 120-byte RAM, timer, GPIO and interrupt mask
// behind a shared tristate data bus with zero-cycle reads.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_cs,
    input  logic                    mem_we,
    input  logic                    mem_oe,
    input  logic [D_ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0]   mem_data,
    input  logic [7:0]              gpio_in,
    output logic [7:0]              gpio_out,
    output logic                    irq
);

    logic [7:0] ram_q [0:119];
    logic [7:0] gpio_out_q, gpio_out_d;
    logic [1:0] timsk_q, timsk_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic       wr_en, rd_en, is_reg;
    tmr_wr_t    tmr_wr;
    logic [7:0] rd_data;
    logic [7:0] tcnt, ocr;
    logic [3:0] tccr;
    logic [1:0] tifr;
    logic       tmr_tick_unused;
    logic [1:0] tmr_flags_unused;

    assign wr_en  = mem_cs && mem_we && reset;
    assign rd_en  = mem_cs && mem_oe && !mem_we && reset;
    assign is_reg = (mem_addr > RAM_TOP);

    data_timer8 u_timer (
        .clk      (clk),
        .reset    (reset),
        .wr       (tmr_wr),
        .wdata    (mem_data),
        .tcnt     (tcnt),
        .tccr     (tccr),
        .ocr      (ocr),
        .tifr     (tifr),
        .tick     (tmr_tick_unused),
        .flag_set (tmr_flags_unused)
    );

    // Write decode for timer strobes and local registers
    always_comb begin
        tmr_wr     = '0;
        gpio_out_d = gpio_out_q;
        timsk_d    = timsk_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        if (wr_en) begin
            case (mem_addr)
                ADDR_TCNT:  tmr_wr.tcnt = 1'b1;
                ADDR_TCCR:  tmr_wr.tccr = 1'b1;
                ADDR_OCR:   tmr_wr.ocr  = 1'b1;
                ADDR_TIFR:  tmr_wr.tifr = 1'b1;
                ADDR_GPO:   gpio_out_d  = mem_data;
                ADDR_TIMSK: timsk_d     = mem_data[1:0];
                default:    ;
            endcase
        end
    end

    // Read mux over RAM and registers, returning pre-edge state
    always_comb begin
        rd_data = '0;
        if (!is_reg) begin
            rd_data = ram_q[mem_addr];
        end else begin
            case (mem_addr)
                ADDR_TCNT:  rd_data = tcnt;
                ADDR_TCCR:  rd_data = {4'b0, tccr};
                ADDR_OCR:   rd_data = ocr;
                ADDR_TIFR:  rd_data = {6'b0, tifr};
                ADDR_GPO:   rd_data = gpio_out_q;
                ADDR_GPI:   rd_data = sync2_q;
                ADDR_TIMSK: rd_data = {6'b0, timsk_q};
                default:    rd_data = '0;
            endcase
        end
    end

    // RAM storage, not reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (wr_en && !is_reg) begin
            ram_q[mem_addr] <= mem_data;
        end
    end

    // GPIO output, interrupt mask and input synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            timsk_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            timsk_q    <= timsk_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign mem_data = rd_en ? rd_data : {DATA_WIDTH{1'bz}};
    assign gpio_out = gpio_out_q;
    assign irq      = |(tifr & timsk_q);

endmodule
